ifetch: RTL
===========

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter ICACHE_IDX_W, default 4, log2 of direct-mapped icache entries (one 32-bit instruction each).
REQ-002 Parameter RESET_PC, default 32'h0, PC value loaded at reset.
REQ-003 clk_in  input  1  single clock; all state changes on posedge.
REQ-004 rst_in  input  1  asynchronous, active-low reset.
REQ-005 rdy_in  input  1  global enable; when low, all state and outputs hold.
REQ-006 clear_branch_in  input  1  misprediction flush.
REQ-007 branch_pc_in  input  32  redirect PC, valid with clear_branch_in.
REQ-008 iq_full_in  input  1  downstream instruction queue cannot accept.
REQ-009 if_to_iq_en_out  output  1  one-cycle pulse, instruction valid.
REQ-010 if_instr_out  output  32  fetched instruction.
REQ-011 if_pc_out  output  32  PC of if_instr_out.
REQ-012 if_to_alloc_en_out  output  1  memory read request to allocator.
REQ-013 if_a_out  output  32  request byte address.
REQ-014 if_offset_out  output  2  last byte index of request; constant 2'b11.
REQ-015 alloc_to_if_gr_in  input  1  one-cycle pulse, request granted.
REQ-016 alloc_to_if_en_in  input  1  one-cycle pulse, if_d_in valid.
REQ-017 if_d_in  input  32  little-endian instruction word from allocator.

Function
REQ-018 FSM states: IDLE, REQ, WAIT; only IDLE issues instructions.
REQ-019 Cache index = pc[ICACHE_IDX_W+1:2]; tag = pc[31:ICACHE_IDX_W+2]; per-entry valid bit.
REQ-020 IDLE, hit, iq_full_in low: next cycle if_to_iq_en_out=1, if_instr_out=entry data, if_pc_out=pc; pc <= pc+4 (mod 2^32); one instruction per cycle sustained.
REQ-021 IDLE, hit, iq_full_in high: no issue, pc unchanged, if_to_iq_en_out=0.
REQ-022 IDLE, miss: next cycle state REQ, if_to_alloc_en_out=1, if_a_out=pc; miss handled regardless of iq_full_in.
REQ-023 REQ: hold if_to_alloc_en_out and if_a_out until alloc_to_if_gr_in; in the cycle after gr, if_to_alloc_en_out=0, state WAIT.
REQ-024 WAIT: if_a_out and if_offset_out stable (allocator reads them through the transfer); if_to_alloc_en_out=0.
REQ-025 WAIT + alloc_to_if_en_in: write if_d_in into entry at index(pc), set valid, tag(pc); state IDLE; instruction issued by normal hit path (miss-to-issue latency: en pulse +2 cycles minimum).
REQ-026 alloc_to_if_en_in outside WAIT is ignored; alloc_to_if_gr_in outside REQ is ignored.
REQ-027 clear_branch_in (any state): pc <= branch_pc_in, state IDLE, if_to_alloc_en_out=0, if_to_iq_en_out=0 next cycle; no cache write that cycle even if alloc_to_if_en_in coincides; cache contents retained.
REQ-028 clear_branch_in has priority over every other event in the same cycle.
REQ-029 if_to_iq_en_out deasserts every cycle no issue occurs; never high two cycles for same pc.
REQ-030 rdy_in low: no state, pc, cache or output change (pulses held as-is).

Reset
REQ-031 rst_in low (async): state IDLE, pc=RESET_PC, all valid bits 0, if_to_iq_en_out=0, if_instr_out=0, if_pc_out=0, if_to_alloc_en_out=0, if_a_out=0; if_offset_out=2'b11 always.
REQ-032 Reset mid-transfer discards pending fill; no cache write after reset release until a new REQ/WAIT completes.

Verification
REQ-033 Cold start RESET_PC=0: REQ with if_a_out=0 -> gr 2 cycles later, en with if_d_in=32'h00000013 -> if_to_iq_en_out=1, if_instr_out=32'h13, if_pc_out=0; next request at 0x4.
REQ-034 Warm loop: entries 0x0-0xC prefilled, iq_full_in=0 -> four consecutive issue pulses, pc 0,4,8,C, no allocator requests.
REQ-035 Back-pressure: hit at 0x8 with iq_full_in=1 for 3 cycles -> no pulse, pc stays 0x8; drop iq_full_in -> single pulse pc=0x8.
REQ-036 Flush in WAIT: clear_branch_in=1, branch_pc_in=0x100, same cycle as en -> no cache write, next request if_a_out=0x100.
REQ-037 Conflict: fill 0x0 then fetch 0x40 (ICACHE_IDX_W=4) -> miss, replaces index 0; refetch 0x0 -> miss again.
REQ-038 Async reset asserted in REQ -> if_to_alloc_en_out=0 immediately without clock edge; later en pulse ignored.

Source files
------------

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch -- instruction fetch unit with a direct-mapped instruction cache.
//
// Each cycle in IDLE the current pc is looked up in the icache. A hit issues
// the cached word to the instruction queue (one per cycle while the queue can
// accept). A miss sends a word read request to the memory allocator. The unit
// waits for the grant, then for the data beat. The returned word is written
// into the cache, and the normal hit path then issues it.
//
// Ports
//   clk_in              single clock, rising edge
//   rst_in              asynchronous active-low reset
//   rdy_in              global enable; low freezes all state and outputs
//   clear_branch_in     misprediction flush, highest priority
//   branch_pc_in        redirect pc, valid with clear_branch_in
//   iq_full_in          instruction queue cannot accept this cycle
//   if_to_iq_en_out     one-cycle pulse, if_instr_out/if_pc_out valid
//   if_instr_out        fetched instruction
//   if_pc_out           pc of if_instr_out
//   if_to_alloc_en_out  read request to the allocator (held until granted)
//   if_a_out            request byte address (stable through the transfer)
//   if_offset_out       last byte index of the request, always 2'b11
//   alloc_to_if_gr_in   one-cycle pulse, request granted
//   alloc_to_if_en_in   one-cycle pulse, if_d_in valid
//   if_d_in             little-endian instruction word from the allocator
// ----------------------------------------------------------------------------
module ifetch #(
  parameter int unsigned ICACHE_IDX_W = 4,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_branch_in,
  input  logic [31:0] branch_pc_in,
  input  logic        iq_full_in,
  output logic        if_to_iq_en_out,
  output logic [31:0] if_instr_out,
  output logic [31:0] if_pc_out,
  output logic        if_to_alloc_en_out,
  output logic [31:0] if_a_out,
  output logic [1:0]  if_offset_out,
  input  logic        alloc_to_if_gr_in,
  input  logic        alloc_to_if_en_in,
  input  logic [31:0] if_d_in
);

  localparam int unsigned DEPTH = 1 << ICACHE_IDX_W;
  localparam int unsigned TAG_W = 32 - ICACHE_IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t                  r_state;
  logic [31:0]             r_pc;
  logic [DEPTH-1:0]        r_valid;
  logic [TAG_W-1:0]        r_tag  [DEPTH];
  logic [31:0]             r_data [DEPTH];

  logic [ICACHE_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  logic                    w_fill;

  assign w_idx = r_pc[ICACHE_IDX_W+1:2];
  assign w_tag = r_pc[31:ICACHE_IDX_W+2];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // A fill happens only while waiting for data. A flush in the same cycle
  // cancels it. Reset forces the state out of S_WAIT asynchronously, so a
  // pending transfer can never land after reset.
  assign w_fill = rdy_in && !clear_branch_in && (r_state == S_WAIT) && alloc_to_if_en_in;

  // The request always covers a whole 32-bit word.
  assign if_offset_out = 2'b11;

  // NOTE: the data and tag arrays are deliberately left unreset. Only the
  // valid bits need a known value; that keeps the storage mappable to RAM.
  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_data[w_idx] <= if_d_in;
      r_tag[w_idx]  <= w_tag;
    end
  end

  // NOTE: every sequential assignment uses <=. All registers below then see
  // the pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state            <= S_IDLE;
      r_pc               <= RESET_PC;
      r_valid            <= '0;
      if_to_iq_en_out    <= 1'b0;
      if_instr_out       <= '0;
      if_pc_out          <= '0;
      if_to_alloc_en_out <= 1'b0;
      if_a_out           <= '0;
    end else if (rdy_in) begin
      if (clear_branch_in) begin
        // A flush overrides everything; cache contents are kept.
        r_state            <= S_IDLE;
        r_pc               <= branch_pc_in;
        if_to_iq_en_out    <= 1'b0;
        if_to_alloc_en_out <= 1'b0;
      end else begin
        // The issue pulse is re-armed only by an actual issue below.
        if_to_iq_en_out <= 1'b0;
        unique case (r_state)
          S_IDLE: begin
            if (w_hit) begin
              if (!iq_full_in) begin
                if_to_iq_en_out <= 1'b1;
                if_instr_out    <= r_data[w_idx];
                if_pc_out       <= r_pc;
                r_pc            <= r_pc + 32'd4;
              end
            end else begin
              // A miss is serviced even while the queue is full.
              r_state            <= S_REQ;
              if_to_alloc_en_out <= 1'b1;
              if_a_out           <= r_pc;
            end
          end
          S_REQ: begin
            if (alloc_to_if_gr_in) begin
              r_state            <= S_WAIT;
              if_to_alloc_en_out <= 1'b0;
            end
          end
          S_WAIT: begin
            // if_a_out holds its value: the allocator reads it during the transfer.
            if (alloc_to_if_en_in) begin
              r_valid[w_idx] <= 1'b1;
              r_state        <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
